// File: rtl/jt5911_ctrl.sv
// jt5911_ctrl: parallel-request serial master for an ER5911-compatible EEPROM.
// Each accepted command is framed, shifted out on sclk/sdi, and read data is returned in parallel.
module jt5911_ctrl #(
    parameter int unsigned AW      = 7,
    parameter int unsigned DW      = 8,
    parameter int unsigned CLKDIV  = 4,
    parameter int unsigned CSSETUP = 6,
    parameter int unsigned CSLOW   = 6,
    parameter int unsigned TMO     = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          done,
    output logic          err,
    output logic          sclk,
    output logic          sdi,
    output logic          scs,
    input  logic          sdo,
    input  logic          rdy
);
    localparam int unsigned FrameW = 5 + AW + DW;
    localparam int unsigned CntW   = $clog2(AW + DW + 6);
    localparam int unsigned DivW   = $clog2(CLKDIV) + 1;
    localparam int unsigned TmoW   = $clog2(TMO + 1);

    localparam logic [2:0] OpRead  = 3'd0;
    localparam logic [2:0] OpWrite = 3'd1;
    localparam logic [2:0] OpEwen  = 3'd2;
    localparam logic [2:0] OpEwds  = 3'd3;
    localparam logic [2:0] OpEral  = 3'd4;

    localparam logic [DivW-1:0] DivRise  = DivW'(CLKDIV - 1);
    localparam logic [DivW-1:0] DivEnd   = DivW'(2 * CLKDIV - 1);
    localparam logic [CntW-1:0] CntSetup = CntW'(CSSETUP - 1);
    localparam logic [CntW-1:0] CntCmd   = CntW'(4 + AW);
    localparam logic [CntW-1:0] CntWr    = CntW'(DW - 1);
    localparam logic [CntW-1:0] CntRd    = CntW'(DW);
    localparam logic [CntW-1:0] CntLow   = CntW'(CSLOW - 1);
    localparam logic [TmoW-1:0] TmoLast  = TmoW'(TMO - 1);

    typedef enum logic [3:0] {
        StIdle, StIll, StCsup, StPre, StCmd, StWdat, StRdin, StPoll, StCsdn
    } state_e;

    state_e              r_state;
    logic [2:0]          r_op;
    logic [FrameW-1:0]   r_sh;
    logic [DW-1:0]       r_rsh;
    logic [CntW-1:0]     r_cnt;
    logic [DivW-1:0]     r_div;
    logic [TmoW-1:0]     r_tmo;
    logic                r_seen0;
    logic [1:0]          r_hi;
    logic                r_ready;
    logic [DW-1:0]       r_rd_data;
    logic                r_rd_valid;
    logic                r_done;
    logic                r_err;
    logic                r_sclk;
    logic                r_sdi;
    logic                r_scs;

    logic [3:0]          w_nib;
    logic [AW-1:0]       w_addr;
    logic [DW-1:0]       w_data;
    logic [FrameW-1:0]   w_frame;
    logic                w_illegal;
    logic [1:0]          w_hi_n;
    logic                w_poll_ok;

    // Frame is start bit, opcode nibble, address, data; unused fields are zero.
    always_comb begin
        w_nib  = 4'b0000;
        w_addr = '0;
        w_data = '0;
        case (cmd_op)
            OpRead:  begin w_nib = 4'b1000; w_addr = cmd_addr; end
            OpWrite: begin w_nib = 4'b1100; w_addr = cmd_addr; w_data = cmd_data; end
            OpEwen:  w_nib = 4'b0011;
            OpEwds:  w_nib = 4'b0000;
            OpEral:  w_nib = 4'b0010;
            default: w_nib = 4'b0000;
        endcase
    end

    assign w_frame   = {1'b1, w_nib, w_addr, w_data};
    assign w_illegal = (cmd_op > OpEral);

    // Busy end: a 0->1 on rdy, or a steady high rdy once the EEPROM has had time to drop it.
    always_comb begin
        w_hi_n = 2'd0;
        if (rdy) w_hi_n = (r_hi == 2'd3) ? 2'd3 : r_hi + 2'd1;
    end
    assign w_poll_ok = rdy && (r_seen0 || (w_hi_n == 2'd3 && r_tmo >= TmoW'(3)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_op       <= '0;
            r_sh       <= '0;
            r_rsh      <= '0;
            r_cnt      <= '0;
            r_div      <= '0;
            r_tmo      <= '0;
            r_seen0    <= 1'b0;
            r_hi       <= '0;
            r_ready    <= 1'b1;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_sclk     <= 1'b0;
            r_sdi      <= 1'b0;
            r_scs      <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (cmd_valid && r_ready) begin
                        r_ready <= 1'b0;
                        r_op    <= cmd_op;
                        r_sh    <= w_frame;
                        if (w_illegal) begin
                            r_err   <= 1'b1;
                            r_state <= StIll;
                        end else begin
                            r_err   <= 1'b0;
                            r_scs   <= 1'b1;
                            r_cnt   <= CntSetup;
                            r_state <= StCsup;
                        end
                    end
                end
                StIll: begin
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= StIdle;
                end
                StCsup: begin
                    if (r_cnt == '0) begin
                        r_div   <= '0;
                        r_sdi   <= 1'b0;
                        r_state <= StPre;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StPre, StCmd, StWdat, StRdin: begin
                    r_div <= r_div + 1'b1;
                    if (r_div == DivRise) r_sclk <= 1'b1;
                    // Falling edge: sample sdo, present the next bit, advance the bit count.
                    if (r_div == DivEnd) begin
                        r_sclk <= 1'b0;
                        r_div  <= '0;
                        r_rsh  <= {r_rsh[DW-2:0], sdo};
                        case (r_state)
                            StPre: begin
                                r_sdi   <= r_sh[FrameW-1];
                                r_sh    <= {r_sh[FrameW-2:0], 1'b0};
                                r_cnt   <= CntCmd;
                                r_state <= StCmd;
                            end
                            StCmd: begin
                                if (r_cnt != '0) begin
                                    r_sdi <= r_sh[FrameW-1];
                                    r_sh  <= {r_sh[FrameW-2:0], 1'b0};
                                    r_cnt <= r_cnt - 1'b1;
                                end else begin
                                    case (r_op)
                                        OpRead: begin
                                            r_sdi   <= 1'b0;
                                            r_cnt   <= CntRd;
                                            r_state <= StRdin;
                                        end
                                        OpWrite: begin
                                            r_sdi   <= r_sh[FrameW-1];
                                            r_sh    <= {r_sh[FrameW-2:0], 1'b0};
                                            r_cnt   <= CntWr;
                                            r_state <= StWdat;
                                        end
                                        OpEral: begin
                                            r_sdi   <= 1'b0;
                                            r_tmo   <= '0;
                                            r_seen0 <= 1'b0;
                                            r_hi    <= '0;
                                            r_state <= StPoll;
                                        end
                                        default: begin
                                            r_scs   <= 1'b0;
                                            r_sdi   <= 1'b0;
                                            r_cnt   <= CntLow;
                                            r_state <= StCsdn;
                                        end
                                    endcase
                                end
                            end
                            StWdat: begin
                                if (r_cnt != '0) begin
                                    r_sdi <= r_sh[FrameW-1];
                                    r_sh  <= {r_sh[FrameW-2:0], 1'b0};
                                    r_cnt <= r_cnt - 1'b1;
                                end else begin
                                    r_scs   <= 1'b0;
                                    r_sdi   <= 1'b0;
                                    r_cnt   <= CntLow;
                                    r_state <= StCsdn;
                                end
                            end
                            default: begin
                                if (r_cnt != '0) begin
                                    r_cnt <= r_cnt - 1'b1;
                                end else begin
                                    r_rd_data  <= {r_rsh[DW-2:0], sdo};
                                    r_rd_valid <= 1'b1;
                                    r_scs      <= 1'b0;
                                    r_cnt      <= CntLow;
                                    r_state    <= StCsdn;
                                end
                            end
                        endcase
                    end
                end
                StPoll: begin
                    r_tmo <= r_tmo + 1'b1;
                    r_hi  <= w_hi_n;
                    if (!rdy) r_seen0 <= 1'b1;
                    if (w_poll_ok || r_tmo == TmoLast) begin
                        if (!w_poll_ok) r_err <= 1'b1;
                        r_scs   <= 1'b0;
                        r_cnt   <= CntLow;
                        r_state <= StCsdn;
                    end
                end
                StCsdn: begin
                    if (r_cnt == '0) begin
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign done      = r_done;
    assign err       = r_err;
    assign sclk      = r_sclk;
    assign sdi       = r_sdi;
    assign scs       = r_scs;

endmodule
